coax_bus_controller: RTL

- Host-side master for the coax interface parallel bus: tx_load/tx_full/tx_active, rx_enable/rx_active/rx_data_available/rx_data_read and the shared 10-bit data bus.
- Takes outbound 10-bit coax words from a valid/ready stream and pushes them into the transmitter.
- Manages bus direction with turnaround gaps, then collects response words into a second valid/ready stream.
- Same clock domain as the interface (19 MHz PLL clock); sits between a command sequencer and the interface pins.

---
 rtl/coax_bus_pkg.sv | 27 ++
 rtl/coax_bus_turnaround.sv | 30 +++
 rtl/coax_bus_controller.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/coax_bus_pkg.sv
// Shared types and sizing for the coax bus master: FSM state encoding,
// word width and the width of the shared turnaround/timeout counter.
package coax_bus_pkg;

   localparam int WORD_WIDTH            = 10;
   localparam int DEF_TURNAROUND_CYCLES = 2;
   localparam int DEF_TX_START_TIMEOUT  = 64;
   localparam int DEF_RESPONSE_TIMEOUT  = 1024;

   localparam int MAX_TIMEOUT = (DEF_TX_START_TIMEOUT > DEF_RESPONSE_TIMEOUT) ?
                                DEF_TX_START_TIMEOUT : DEF_RESPONSE_TIMEOUT;
   // The TX start timer is loaded with the full timeout value, so it needs +1.
   localparam int CNT_WIDTH   = $clog2(MAX_TIMEOUT + 1);

   typedef enum logic [3:0] {
      RX_IDLE   = 4'd0,
      RX_READ   = 4'd1,
      RX_HOLD   = 4'd2,
      TURN_TX   = 4'd3,
      TX_DRIVE  = 4'd4,
      TX_START  = 4'd5,
      TX_WAIT   = 4'd6,
      TURN_RX   = 4'd7,
      RESP_WAIT = 4'd8
   } state_t;

endpackage

// File: rtl/coax_bus_turnaround.sv
// Loadable saturating down-counter shared by the bus turnaround gaps,
// the RX hold window and both timeouts; done is the terminal-count compare.
module coax_bus_turnaround
   import coax_bus_pkg::*;
#(
   parameter logic [CNT_WIDTH-1:0] RESET_VALUE = '0
)(
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 load,
   input  logic [CNT_WIDTH-1:0] load_value,
   input  logic                 en,
   output logic                 done
);

   logic [CNT_WIDTH-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt <= RESET_VALUE;
      end else if (load) begin
         cnt <= load_value;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign done = (cnt == '0);

endmodule

// File: rtl/coax_bus_controller.sv
// Host-side master for the coax interface parallel bus: pushes outbound words
// into the transmitter, turns the bus around and collects response words.
//
//   state     | meaning
//   ----------+-----------------------------------------------------------
//   RX_IDLE   | receiver enabled, waiting for outbound word or unsolicited rx
//   RX_READ   | capture bus word into rx_rdata, pulse rx_data_read
//   RX_HOLD   | 2 cycles for the registered data_available to see the read
//   TURN_TX   | turnaround gap before driving the bus
//   TX_DRIVE  | drive bus, load words into the transmitter
//   TX_START  | wait for tx_active to rise (TX start timeout)
//   TX_WAIT   | wait for tx_active to fall
//   TURN_RX   | turnaround gap before enabling the receiver
//   RESP_WAIT | receiver enabled, wait for first response word (timeout)
module coax_bus_controller
   import coax_bus_pkg::*;
#(
   parameter int TURNAROUND_CYCLES = DEF_TURNAROUND_CYCLES,
   parameter int TX_START_TIMEOUT  = DEF_TX_START_TIMEOUT,
   parameter int RESPONSE_TIMEOUT  = DEF_RESPONSE_TIMEOUT
)(
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [WORD_WIDTH-1:0] tx_wdata,
   input  logic                  tx_wlast,
   input  logic                  tx_wvalid,
   output logic                  tx_wready,
   output logic [WORD_WIDTH-1:0] rx_rdata,
   output logic                  rx_rvalid,
   input  logic                  rx_rready,
   output logic                  timeout,
   output logic                  busy,
   output logic                  bus_tx_load,
   input  logic                  bus_tx_full,
   input  logic                  bus_tx_active,
   output logic                  bus_rx_enable,
   input  logic                  bus_rx_active,
   input  logic                  bus_rx_data_available,
   output logic                  bus_rx_data_read,
   input  logic [WORD_WIDTH-1:0] bus_data_in,
   output logic [WORD_WIDTH-1:0] bus_data_out,
   output logic                  bus_data_oe
);

   localparam logic [CNT_WIDTH-1:0] TURN_LOAD = CNT_WIDTH'(TURNAROUND_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] HOLD_LOAD = CNT_WIDTH'(1);
   localparam logic [CNT_WIDTH-1:0] TXS_LOAD  = CNT_WIDTH'(TX_START_TIMEOUT);
   localparam logic [CNT_WIDTH-1:0] RESP_LOAD = CNT_WIDTH'(RESPONSE_TIMEOUT - 1);

   state_t                state, state_nxt;
   logic                  tx_full_q, tx_active_q, rx_active_q, data_available_q;
   logic [WORD_WIDTH-1:0] data_in_q;
   logic                  load_q;
   logic                  accept;
   logic                  cnt_load, cnt_en, cnt_done;
   logic [CNT_WIDTH-1:0]  cnt_value;

   coax_bus_turnaround #(
      .RESET_VALUE (TURN_LOAD)
   ) u_timer (
      .clk        (clk),
      .reset_n    (reset_n),
      .load       (cnt_load),
      .load_value (cnt_value),
      .en         (cnt_en),
      .done       (cnt_done)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state            <= TURN_RX;
         tx_full_q        <= 1'b0;
         tx_active_q      <= 1'b0;
         rx_active_q      <= 1'b0;
         data_available_q <= 1'b0;
         data_in_q        <= '0;
         load_q           <= 1'b0;
         rx_rvalid        <= 1'b0;
         rx_rdata         <= '0;
      end else begin
         state            <= state_nxt;
         tx_full_q        <= bus_tx_full;
         tx_active_q      <= bus_tx_active;
         rx_active_q      <= bus_rx_active;
         data_available_q <= bus_rx_data_available;
         data_in_q        <= bus_data_in;
         load_q           <= accept;
         if (state == RX_READ) begin
            rx_rvalid <= 1'b1;
            rx_rdata  <= data_in_q;
         end else if (rx_rvalid && rx_rready) begin
            rx_rvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      state_nxt        = state;
      cnt_load         = 1'b0;
      cnt_value        = TURN_LOAD;
      cnt_en           = 1'b0;
      accept           = 1'b0;
      timeout          = 1'b0;
      bus_rx_enable    = 1'b0;
      bus_data_oe      = 1'b0;
      bus_rx_data_read = 1'b0;
      case (state)
         RX_IDLE: begin
            bus_rx_enable = 1'b1;
            if (tx_wvalid && !rx_rvalid) begin
               state_nxt = TURN_TX;
               cnt_load  = 1'b1;
               cnt_value = TURN_LOAD;
            end else if (!rx_rvalid && data_available_q) begin
               state_nxt = RX_READ;
            end
         end
         RX_READ: begin
            bus_rx_enable    = 1'b1;
            bus_rx_data_read = 1'b1;
            state_nxt        = RX_HOLD;
            cnt_load         = 1'b1;
            cnt_value        = HOLD_LOAD;
         end
         RX_HOLD: begin
            bus_rx_enable = 1'b1;
            cnt_en        = 1'b1;
            if (cnt_done) state_nxt = RX_IDLE;
         end
         TURN_TX: begin
            cnt_en = 1'b1;
            if (cnt_done) state_nxt = TX_DRIVE;
         end
         TX_DRIVE: begin
            bus_data_oe = 1'b1;
            // load_q spaces loads until the registered tx_full can react
            accept = tx_wvalid && !tx_full_q && !load_q;
            if (accept && tx_wlast) begin
               state_nxt = TX_START;
               cnt_load  = 1'b1;
               cnt_value = TXS_LOAD;
            end
         end
         TX_START: begin
            cnt_en = 1'b1;
            if (tx_active_q) begin
               state_nxt = TX_WAIT;
            end else if (cnt_done) begin
               timeout   = 1'b1;
               state_nxt = TURN_RX;
               cnt_load  = 1'b1;
               cnt_value = TURN_LOAD;
            end
         end
         TX_WAIT: begin
            if (!tx_active_q) begin
               state_nxt = TURN_RX;
               cnt_load  = 1'b1;
               cnt_value = TURN_LOAD;
            end
         end
         TURN_RX: begin
            cnt_en = 1'b1;
            if (cnt_done) begin
               state_nxt = RESP_WAIT;
               cnt_load  = 1'b1;
               cnt_value = RESP_LOAD;
            end
         end
         RESP_WAIT: begin
            bus_rx_enable = 1'b1;
            cnt_en        = !rx_active_q;
            if (data_available_q && !rx_rvalid) begin
               state_nxt = RX_READ;
            end else if (cnt_done) begin
               timeout   = 1'b1;
               state_nxt = RX_IDLE;
            end
         end
         default: state_nxt = RX_IDLE;
      endcase
   end

   assign bus_tx_load  = accept;
   assign tx_wready    = accept;
   assign bus_data_out = (state == TX_DRIVE) ? tx_wdata : '0;
   assign busy         = (state != RX_IDLE);

endmodule
